vga_timing_gen: RTL and testbench

- Parametrised raster timing generator; next generation of the fixed 640x480@60 sync block.
- Programmable active, porch and sync widths per axis, and sync polarity per axis.
- Pixel clock-enable lets one fast clock drive any mode.
- Exposes the current pixel coordinate to the pixel source and returns its colour one pixel later, aligned with registered syncs and data enable, feeding the HDMI transmitter.

---
 rtl/vga_timing_pkg.sv | 51 +++++
 rtl/vga_timing_gen_axis_counter.sv | 45 ++++
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the raster timing generator: standard mode bundles,
// default colour width and the colour-bar palette used by the test pattern.
`timescale 1ns/1ps
package vga_timing_pkg;

   typedef struct packed {
      int unsigned h_active;
      int unsigned h_fp;
      int unsigned h_sync;
      int unsigned h_bp;
      int unsigned v_active;
      int unsigned v_fp;
      int unsigned v_sync;
      int unsigned v_bp;
      logic        h_pol;
      logic        v_pol;
   } vga_mode_t;

   localparam vga_mode_t VGA_640x480 = '{
      h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33,
      h_pol: 1'b0, v_pol: 1'b0};

   localparam vga_mode_t SVGA_800x600 = '{
      h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
      v_active: 600, v_fp: 1, v_sync: 4, v_bp: 23,
      h_pol: 1'b1, v_pol: 1'b1};

   localparam vga_mode_t HD_1280x720 = '{
      h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
      v_active: 720, v_fp: 5, v_sync: 5, v_bp: 20,
      h_pol: 1'b1, v_pol: 1'b1};

   localparam int RGB_W_DEFAULT = 24;
   localparam int NUM_BARS      = 8;

   // {red, green, blue} on/off code per bar, left to right across the line
   function automatic logic [2:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_colour = 3'b111;
         3'd1:    bar_colour = 3'b110;
         3'd2:    bar_colour = 3'b011;
         3'd3:    bar_colour = 3'b010;
         3'd4:    bar_colour = 3'b101;
         3'd5:    bar_colour = 3'b100;
         3'd6:    bar_colour = 3'b001;
         default: bar_colour = 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter, terminal-count flag and
// constant-bound decode of the sync window and visible region.
`timescale 1ns/1ps
module vga_axis_counter #(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter int CNT_W  = 11
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             tc,
   output logic             sync_raw,
   output logic             in_active
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;

   generate
      if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1)
         $error("vga_axis_counter: every window width must be non-zero");
      if (TOTAL > (1 << CNT_W))
         $error("vga_axis_counter: axis total does not fit in CNT_W bits");
   endgenerate

   localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
   localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (en)
         cnt <= tc ? '0 : cnt + 1'b1;
   end

   assign tc        = (cnt == LAST);
   assign sync_raw  = (cnt >= SYNC_START) && (cnt < SYNC_END);
   assign in_active = (cnt < ACT_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with one-pixel registered output stage.
// Optional colour-bar source enabled by defining VGA_TIMING_TESTPAT_EN.
`timescale 1ns/1ps
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = VGA_640x480.h_active,
   parameter int H_FP     = VGA_640x480.h_fp,
   parameter int H_SYNC   = VGA_640x480.h_sync,
   parameter int H_BP     = VGA_640x480.h_bp,
   parameter int V_ACTIVE = VGA_640x480.v_active,
   parameter int V_FP     = VGA_640x480.v_fp,
   parameter int V_SYNC   = VGA_640x480.v_sync,
   parameter int V_BP     = VGA_640x480.v_bp,
   parameter bit H_POL    = VGA_640x480.h_pol,
   parameter bit V_POL    = VGA_640x480.v_pol,
   parameter int CNT_W    = 11,
   parameter int RGB_W    = RGB_W_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pix_ce,
   input  logic [RGB_W-1:0] rgb_in,
   input  logic             test_mode,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             active,
   output logic             hsync,
   output logic             vsync,
   output logic             data_enable,
   output logic [RGB_W-1:0] rgb_out,
   output logic             line_start,
   output logic             frame_start
);

   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             h_tc, v_tc_unused;
   logic             h_sync_raw, v_sync_raw;
   logic             h_act, v_act;
   logic [RGB_W-1:0] src_rgb;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
   ) u_h_axis (
      .clock     (clock),
      .reset     (reset),
      .en        (pix_ce),
      .cnt       (h_cnt),
      .tc        (h_tc),
      .sync_raw  (h_sync_raw),
      .in_active (h_act)
   );

   // Vertical axis steps on the same edge the horizontal counter wraps.
   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
   ) u_v_axis (
      .clock     (clock),
      .reset     (reset),
      .en        (pix_ce & h_tc),
      .cnt       (v_cnt),
      .tc        (v_tc_unused),
      .sync_raw  (v_sync_raw),
      .in_active (v_act)
   );

   assign x      = h_cnt;
   assign y      = v_cnt;
   assign active = h_act & v_act;

`ifdef VGA_TIMING_TESTPAT_EN
   localparam int CH = RGB_W / 3;

   logic [2:0]       bar_idx;
   logic [2:0]       bar_code;
   logic [RGB_W-1:0] bar_rgb;

   // Bar k starts at ceil(k*H_ACTIVE/8), i.e. floor(x*8/H_ACTIVE) as compares.
   always_comb begin
      bar_idx = '0;
      for (int k = 1; k < NUM_BARS; k++) begin
         if (h_cnt >= CNT_W'((k * H_ACTIVE + NUM_BARS - 1) / NUM_BARS))
            bar_idx = 3'(k);
      end
      bar_code = bar_colour(bar_idx);
      bar_rgb  = '0;
      bar_rgb[3*CH-1:0] = {{CH{bar_code[2]}}, {CH{bar_code[1]}}, {CH{bar_code[0]}}};
   end

   assign src_rgb = test_mode ? bar_rgb : rgb_in;
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
   assign src_rgb          = rgb_in;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hsync       <= !H_POL;
         vsync       <= !V_POL;
         data_enable <= 1'b0;
         rgb_out     <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (pix_ce) begin
         hsync       <= h_sync_raw ^ !H_POL;
         vsync       <= v_sync_raw ^ !V_POL;
         data_enable <= active;
         rgb_out     <= active ? src_rgb : '0;
         line_start  <= (h_cnt == '0);
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: tiny raster mode (16x8) plus a 640x480 instance with
// active-high syncs for the line-timing check.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic pix_ce = 1'b0;
   logic pix_ce_b = 1'b0;
   logic test_mode = 1'b0;

   logic [10:0] x, y, x_b, y_b;
   logic [23:0] rgb_in, rgb_in_b, rgb_out, rgb_out_b;
   logic active, hsync, vsync, data_enable, line_start, frame_start;
   logic active_b, hsync_b, vsync_b, de_b, ls_b, fs_b;

   assign rgb_in   = {x[7:0], y[7:0], 8'h5A};
   assign rgb_in_b = {x_b[7:0], y_b[7:0], 8'hA5};

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
      .H_POL(1'b0), .V_POL(1'b0), .CNT_W(11), .RGB_W(24)
   ) dut (
      .clock(clock), .reset(reset), .pix_ce(pix_ce), .rgb_in(rgb_in),
      .test_mode(test_mode), .x(x), .y(y), .active(active), .hsync(hsync),
      .vsync(vsync), .data_enable(data_enable), .rgb_out(rgb_out),
      .line_start(line_start), .frame_start(frame_start)
   );

   vga_timing_gen #(.H_POL(1'b1), .V_POL(1'b1)) dut_big (
      .clock(clock), .reset(reset), .pix_ce(pix_ce_b), .rgb_in(rgb_in_b),
      .test_mode(1'b0), .x(x_b), .y(y_b), .active(active_b), .hsync(hsync_b),
      .vsync(vsync_b), .data_enable(de_b), .rgb_out(rgb_out_b),
      .line_start(ls_b), .frame_start(fs_b)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Returns once the tiny DUT presents (px,py); checks current values first.
   task automatic goto_xy(input int px, input int py);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (int'(x) == px && int'(y) == py) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (!ok) check("goto_xy_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      int   px;
      int   py;
      logic hs;
      logic vs;
      logic de;
      logic ls;
      logic fs;
   } vec_t;

   vec_t vecs[14];
   logic [23:0] bars[8];

   initial begin
      int hs_fall[$];
      int fs_rise[$];
      int vs_low, de_high, rgb_err, zero_err, hold_err, vs_b_err;
      int first_hs, hs_len, next_ls;
      logic prev_hs, prev_fs;
      logic [23:0] exp_rgb;
      logic [70:0] snap;

      // {pre-edge x, pre-edge y, hsync, vsync, data_enable, line_start, frame_start}
      vecs[0]  = '{0,  0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[1]  = '{7,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{8,  0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{9,  1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{10, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{11, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{12, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{0,  3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{15, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{3,  4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{0,  5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{10, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{15, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{0,  0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_hsync", hsync, 1);
      check("rst_vsync", vsync, 1);
      check("rst_de", data_enable, 0);
      check("rst_rgb", rgb_out, 0);
      check("rst_ls", line_start, 0);
      check("rst_fs", frame_start, 0);
      check("rst_big_hsync", hsync_b, 0);

      // Table vectors at full rate
      reset  = 1'b0;
      pix_ce = 1'b1;
      foreach (vecs[i]) begin
         goto_xy(vecs[i].px, vecs[i].py);
         exp_rgb = vecs[i].de ? {8'(vecs[i].px), 8'(vecs[i].py), 8'h5A} : 24'h0;
         @(posedge clock);
         #1;
         check($sformatf("v%0d_hsync", i), hsync, vecs[i].hs);
         check($sformatf("v%0d_vsync", i), vsync, vecs[i].vs);
         check($sformatf("v%0d_de", i), data_enable, vecs[i].de);
         check($sformatf("v%0d_ls", i), line_start, vecs[i].ls);
         check($sformatf("v%0d_fs", i), frame_start, vecs[i].fs);
         check($sformatf("v%0d_rgb", i), rgb_out, exp_rgb);
      end

      // Full-rate periods and pixel alignment over two frames
      vs_low = 0; de_high = 0; rgb_err = 0; zero_err = 0;
      prev_hs = hsync;
      for (int c = 0; c < 256; c++) begin
         @(negedge clock);
         exp_rgb = active ? {x[7:0], y[7:0], 8'h5A} : 24'h0;
         @(posedge clock);
         #1;
         if (rgb_out !== exp_rgb) rgb_err++;
         if (!data_enable && rgb_out !== 24'h0) zero_err++;
         if (prev_hs && !hsync) hs_fall.push_back(c);
         prev_hs = hsync;
         if (c < 128) begin
            if (!vsync) vs_low++;
            if (data_enable) de_high++;
         end
      end
      check("full_rgb_align_errs", rgb_err, 0);
      check("full_rgb_zero_errs", zero_err, 0);
      check("full_vsync_low_per_frame", vs_low, 16);
      check("full_de_high_per_frame", de_high, 32);
      if (hs_fall.size() >= 2) check("full_hsync_period", hs_fall[1] - hs_fall[0], 16);
      else check("full_hsync_falls", hs_fall.size(), 2);

      // Half-rate cadence: everything holds on pix_ce=0 edges
      hs_fall.delete();
      hold_err = 0;
      prev_hs = hsync;
      prev_fs = frame_start;
      for (int c = 0; c < 1024; c++) begin
         @(negedge clock);
         pix_ce = (c % 2 == 0);
         snap = {hsync, vsync, data_enable, line_start, frame_start, rgb_out, x, y, active};
         @(posedge clock);
         #1;
         if (!pix_ce &&
             snap !== {hsync, vsync, data_enable, line_start, frame_start, rgb_out, x, y, active})
            hold_err++;
         if (prev_hs && !hsync) hs_fall.push_back(c);
         if (!prev_fs && frame_start) fs_rise.push_back(c);
         prev_hs = hsync;
         prev_fs = frame_start;
      end
      check("half_hold_errs", hold_err, 0);
      if (hs_fall.size() >= 2) check("half_hsync_period", hs_fall[1] - hs_fall[0], 32);
      else check("half_hsync_falls", hs_fall.size(), 2);
      if (fs_rise.size() >= 2) check("half_fs_period", fs_rise[1] - fs_rise[0], 256);
      else check("half_fs_rises", fs_rise.size(), 2);

      // Reset mid-frame at (5,2)
      @(negedge clock);
      pix_ce = 1'b1;
      goto_xy(5, 2);
      check("pre_rst_de", data_enable, 1);
      #2 reset = 1'b1;
      #1;
      check("midrst_x", x, 0);
      check("midrst_y", y, 0);
      check("midrst_hsync", hsync, 1);
      check("midrst_vsync", vsync, 1);
      check("midrst_de", data_enable, 0);
      check("midrst_rgb", rgb_out, 0);
      check("midrst_ls", line_start, 0);
      check("midrst_fs", frame_start, 0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("post_rst_fs", frame_start, 1);
      check("post_rst_ls", line_start, 1);
      check("post_rst_de", data_enable, 1);
      check("post_rst_rgb", rgb_out, 24'h00005A);

      // Colour bars across line 0 (rgb passthrough when the feature is absent)
      @(negedge clock);
      reset = 1'b1;
      test_mode = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      for (int px = 0; px < 9; px++) begin
         @(posedge clock);
         #1;
`ifdef VGA_TIMING_TESTPAT_EN
         exp_rgb = (px < 8) ? bars[px] : 24'h0;
`else
         exp_rgb = (px < 8) ? {8'(px), 8'h00, 8'h5A} : 24'h0;
`endif
         check($sformatf("bar_x%0d", px), rgb_out, exp_rgb);
      end
      test_mode = 1'b0;

      // 640x480, active-high syncs: line timing
      pix_ce = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      pix_ce_b = 1'b1;
      @(posedge clock);
      #1;
      check("big_ls0", ls_b, 1);
      check("big_fs0", fs_b, 1);
      first_hs = -1; hs_len = 0; next_ls = -1; vs_b_err = 0;
      for (int n = 1; n <= 800; n++) begin
         @(posedge clock);
         #1;
         if (hsync_b && first_hs < 0) first_hs = n;
         if (hsync_b) hs_len++;
         if (ls_b && next_ls < 0) next_ls = n;
         if (vsync_b) vs_b_err++;
      end
      check("big_hsync_start", first_hs, 656);
      check("big_hsync_len", hs_len, 96);
      check("big_line_period", next_ls, 800);
      check("big_fs_line1", fs_b, 0);
      check("big_y_line1", y_b, 1);
      check("big_vsync_idle", vs_b_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
